// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue/writeback controller: opcodes, FSM states,
// flag and compare bit positions, and opcode classification helpers.
package fpu_pkg;

   localparam logic [6:0] OP_FADD_S  = 7'h00;
   localparam logic [6:0] OP_FADD_D  = 7'h01;
   localparam logic [6:0] OP_FSUB_S  = 7'h04;
   localparam logic [6:0] OP_FSUB_D  = 7'h05;
   localparam logic [6:0] OP_FMUL_S  = 7'h08;
   localparam logic [6:0] OP_FMUL_D  = 7'h09;
   localparam logic [6:0] OP_FDIV_S  = 7'h0C;
   localparam logic [6:0] OP_FDIV_D  = 7'h0D;
   localparam logic [6:0] OP_FSQRT_S = 7'h2C;
   localparam logic [6:0] OP_FSQRT_D = 7'h2D;
   localparam logic [6:0] OP_FCVT_LO = 7'h10;
   localparam logic [6:0] OP_FCVT_HI = 7'h15;
   localparam logic [6:0] OP_FCMP_S  = 7'h50;
   localparam logic [6:0] OP_FCMP_D  = 7'h51;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Bit positions inside fflags / rsp_flags and rsp_cmp.
   localparam int FLAG_NV = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;
   localparam int CMP_LT  = 3;
   localparam int CMP_EQ  = 2;
   localparam int CMP_GT  = 1;
   localparam int CMP_UN  = 0;

   typedef enum logic [2:0] {
      CLS_ADD,
      CLS_MUL,
      CLS_DIV,
      CLS_SQRT,
      CLS_CVT,
      CLS_CMP
   } op_class_e;

   // Unrecognised opcodes fall into the compare class so they get the shortest latency.
   function automatic op_class_e op_class(input logic [6:0] opcode);
      op_class_e cls;
      cls = CLS_CMP;
      if (opcode == OP_FADD_S || opcode == OP_FADD_D ||
          opcode == OP_FSUB_S || opcode == OP_FSUB_D)        cls = CLS_ADD;
      else if (opcode == OP_FMUL_S || opcode == OP_FMUL_D)   cls = CLS_MUL;
      else if (opcode == OP_FDIV_S || opcode == OP_FDIV_D)   cls = CLS_DIV;
      else if (opcode == OP_FSQRT_S || opcode == OP_FSQRT_D) cls = CLS_SQRT;
      else if (opcode >= OP_FCVT_LO && opcode <= OP_FCVT_HI) cls = CLS_CVT;
      return cls;
   endfunction

   function automatic logic is_cmp_op(input logic [6:0] opcode);
      return (opcode == OP_FCMP_S) || (opcode == OP_FCMP_D);
   endfunction

endpackage

// File: rtl/fpu_lat_decode.sv
// Combinational opcode-to-latency lookup; latencies are per-class parameters.
module fpu_lat_decode
   import fpu_pkg::*;
#(
   parameter int LAT_ADD  = 3,
   parameter int LAT_MUL  = 3,
   parameter int LAT_DIV  = 12,
   parameter int LAT_SQRT = 12,
   parameter int LAT_CVT  = 2,
   parameter int LAT_CMP  = 1
) (
   input  logic [6:0] opcode,
   output logic [7:0] lat
);

   // NOTE: every path assigns lat (default first), so no latch is inferred.
   always_comb begin
      lat = 8'(LAT_CMP);
      unique case (op_class(opcode))
         CLS_ADD:  lat = 8'(LAT_ADD);
         CLS_MUL:  lat = 8'(LAT_MUL);
         CLS_DIV:  lat = 8'(LAT_DIV);
         CLS_SQRT: lat = 8'(LAT_SQRT);
         CLS_CVT:  lat = 8'(LAT_CVT);
         CLS_CMP:  lat = 8'(LAT_CMP);
         default:  lat = 8'(LAT_CMP);
      endcase
   end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-outstanding issue/writeback controller in front of the FPU core: holds operands
// for the class latency, captures the core result and accumulates sticky fflags.
module fpu_issue_ctrl
   import fpu_pkg::*;
#(
   parameter int LAT_ADD  = 3,
   parameter int LAT_MUL  = 3,
   parameter int LAT_DIV  = 12,
   parameter int LAT_SQRT = 12,
   parameter int LAT_CVT  = 2,
   parameter int LAT_CMP  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [6:0]  req_opcode,
   input  logic [2:0]  req_rm,
   input  logic [63:0] req_a,
   input  logic [63:0] req_b,
   output logic [6:0]  fpu_opcode,
   output logic [2:0]  fpu_rounding_mode,
   output logic [63:0] fpu_operand_a,
   output logic [63:0] fpu_operand_b,
   input  logic [63:0] fpu_result,
   input  logic [3:0]  fpu_flags,
   input  logic [3:0]  fpu_cmp,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_result,
   output logic [3:0]  rsp_flags,
   output logic [3:0]  rsp_cmp,
   output logic [3:0]  fflags,
   input  logic        fflags_clr
);

   state_e     state;
   logic [7:0] cnt;
   logic [7:0] req_lat;
   logic       accept;
   logic       capture;
   logic       cur_is_cmp;

   fpu_lat_decode #(
      .LAT_ADD  (LAT_ADD),
      .LAT_MUL  (LAT_MUL),
      .LAT_DIV  (LAT_DIV),
      .LAT_SQRT (LAT_SQRT),
      .LAT_CVT  (LAT_CVT),
      .LAT_CMP  (LAT_CMP)
   ) u_lat_decode (
      .opcode (req_opcode),
      .lat    (req_lat)
   );

   assign req_ready  = (state == ST_IDLE);
   assign rsp_valid  = (state == ST_RESP);
   assign accept     = req_ready && req_valid;
   assign capture    = (state == ST_EXEC) && (cnt == 8'd1);
   assign cur_is_cmp = is_cmp_op(fpu_opcode);

   // NOTE: state and datapath registers use non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= ST_IDLE;
         cnt               <= '0;
         fpu_opcode        <= '0;
         fpu_rounding_mode <= '0;
         fpu_operand_a     <= '0;
         fpu_operand_b     <= '0;
         rsp_result        <= '0;
         rsp_flags         <= '0;
         rsp_cmp           <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  fpu_opcode        <= req_opcode;
                  fpu_rounding_mode <= req_rm;
                  fpu_operand_a     <= req_a;
                  fpu_operand_b     <= req_b;
                  cnt               <= req_lat;
                  state             <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               cnt <= cnt - 8'd1;
               if (capture) begin
                  // Compares report only through rsp_cmp; everything else only through rsp_result.
                  rsp_result <= cur_is_cmp ? 64'd0 : fpu_result;
                  rsp_cmp    <= cur_is_cmp ? fpu_cmp : 4'd0;
                  rsp_flags  <= fpu_flags;
                  state      <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // A clear coincident with a capture keeps the freshly captured flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fflags <= '0;
      else        fflags <= (fflags_clr ? 4'd0 : fflags) | (capture ? fpu_flags : 4'd0);
   end

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Single-outstanding issue and writeback controller placed directly in front of the FPU core. It accepts one operation at a time over a valid/ready request port and holds the operands stable at the core inputs for the programmed per-class latency. It then captures the core's result and flags and returns them over a valid/ready response port. It also accumulates the sticky exception flags (fflags).

## Interface
- LAT_ADD, 3: cycles from operand drive to result capture, add/sub
- LAT_MUL, 3: multiply
- LAT_DIV, 12: divide
- LAT_SQRT, 12: square root
- LAT_CVT, 2: conversions
- LAT_CMP, 1: compare and unrecognised opcodes; every LAT_* is ≥1 and ≤255
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_opcode  in  7  FPU opcode
- req_rm  in  3  rounding mode
- req_a, req_b  in  64  operands
- fpu_opcode  out  7  to core
- fpu_rounding_mode  out  3  to core
- fpu_operand_a, fpu_operand_b  out  64  to core
- fpu_result  in  64  from core
- fpu_flags  in  4  {invalid, overflow, underflow, inexact} from core
- fpu_cmp  in  4  {lt, eq, gt, unordered} from core
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid&ready
- rsp_result  out  64  captured result; 0 for compare
- rsp_flags  out  4  captured {NV, OF, UF, NX}
- rsp_cmp  out  4  captured {lt, eq, gt, unordered}; 0 for non-compare
- fflags  out  4  sticky {NV, OF, UF, NX}
- fflags_clr  in  1  synchronous clear of fflags

## Operation
- The FSM has three states: IDLE, EXEC, RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid, latch opcode, rm, a and b into the fpu_* registers.
  - Load the counter with LAT of the opcode class, then go to EXEC.
- **Opcode classes**
  - add/sub: 0x00, 0x01, 0x04, 0x05
  - mul: 0x08, 0x09
  - div: 0x0C, 0x0D
  - sqrt: 0x2C, 0x2D
  - cvt: 0x10–0x15
  - cmp: 0x50, 0x51
  - Any other opcode uses LAT_CMP and is passed through. The core answers such opcodes with QNaN 0x7FF8_0000_0000_0000 plus invalid, and this block forwards that response unchanged.
- **EXEC**
  - The counter decrements once per cycle.
  - In the cycle where counter==1, capture fpu_result, fpu_flags and fpu_cmp into the rsp_* registers, then go to RESP.
  - For a compare, rsp_result is forced to 0. For any other opcode, rsp_cmp is forced to 0.
- **RESP**
  - rsp_valid=1.
  - On rsp_ready, go to IDLE.
  - rsp_* and fpu_* hold their values until the next capture or latch.
- **fflags**
  - fflags_next = (fflags_clr ? 0 : fflags) | (capture ? captured_flags : 0).
  - If clear and capture happen in the same cycle, the new flags survive.
- While busy, req_ready=0. A new request is never accepted in the same cycle as a response handshake.

## Timing
- **Reset values:** state IDLE, req_ready=1, rsp_valid=0, and all of fpu_*, rsp_*, fflags and counter are 0.
- **Latency:** request accepted at edge 0.
  - The fpu_* operands are valid from cycle 1.
  - EXEC covers cycles 1..LAT.
  - Capture happens at the edge ending cycle LAT.
  - rsp_valid is first high in cycle LAT+1.
- **Throughput:** one op per LAT+2 cycles at best (rsp_ready tied 1).
- **Handshake:** rsp_valid, once high, stays high with stable rsp_* until rsp_ready. req_ready is purely a function of state (IDLE).
- **Reset mid-operation:** the in-flight op and its response are discarded with no flag update. fflags returns to 0.

## Structure
- Shared package fpu_pkg holds:
  - opcode localparams
  - the state enum
  - flag index constants (NV=3, OF=2, UF=1, NX=0)
  - the cmp index constants
- Sub-module fpu_lat_decode is combinational: opcode → 8-bit latency, parameterised by the LAT_* values.

## Test plan
- FADD_D 0x01, a=0x3FF0000000000000, b=0x4000000000000000, rsp_ready=1 → rsp_valid first in cycle 4, rsp_result=0x4008000000000000, rsp_flags=0, then req_ready=1 next cycle.
- FCMP_S 0x50, a=0x3F800000, b=0x40000000 → response in cycle 2, rsp_cmp=4'b1000, rsp_result=0, fflags unchanged.
- FDIV_D, a=1.0, b=3.0 → response in cycle 13, NX set in rsp_flags and fflags. Then fflags_clr pulse → fflags=0. Clear coincident with a capture of OF → fflags=4'b0100.
- Opcode 0x7F → response in cycle 2, rsp_result=0x7FF8000000000000, NV set, fflags[3]=1.
- rsp_ready held 0 for 10 cycles → rsp_valid and rsp_* stable, req_ready=0, second req_valid not accepted. Release → second op accepted the cycle after the handshake.
- rst_n asserted during FSQRT EXEC → all outputs return to reset values, and no response appears after release.
